seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 8, number of multiplexed digits; legal range 1..16.
REQ-002 Parameter TICK_DIV, default 100000, clk cycles per digit slot; legal range >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
REQ-005 val_i  input  4*DIGITS  hex nibble per digit; digit k = val_i[4k+3:4k]; digit DIGITS-1 is most significant.
REQ-006 dp_i  input  DIGITS  decimal-point request per digit, 1 = lit.
REQ-007 blank_i  input  DIGITS  per-digit blank request, 1 = dark.
REQ-008 load_i  input  1  single-cycle strobe; captures val_i/dp_i/blank_i into the shadow buffer.
REQ-009 pending_o  output  1  shadow buffer holds data not yet committed to the display.
REQ-010 frame_o  output  1  one-cycle pulse at each scan-frame boundary.
REQ-011 seg_o  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-012 dp_o  output  1  active-low decimal point.
REQ-013 an_o  output  DIGITS  active-low one-hot digit enable.

Function
REQ-014 Prescaler counts 0..TICK_DIV-1 and wraps; tick is asserted in the cycle the count equals TICK_DIV-1.
REQ-015 Digit index counts 0..DIGITS-1, advancing by one on each tick and wrapping DIGITS-1 -> 0.
REQ-016 frame_o is high for exactly the cycle in which a tick wraps the index from DIGITS-1 to 0; when DIGITS=1, every tick is a frame boundary.
REQ-017 On load_i, the inputs are captured into the shadow buffer and pending_o is 1 from the next cycle.
REQ-018 In a frame_o cycle with pending_o=1, the shadow is copied to the active buffer and pending_o clears next cycle.
REQ-019 load_i while pending_o=1 overwrites the shadow; only the last loaded data is committed.
REQ-020 If load_i coincides with a commit, the old shadow commits, the new data is captured, and pending_o stays 1.
REQ-021 seg_o, dp_o and an_o are registered; they reflect the active buffer at the current index, with 1 cycle of latency after each index change.
REQ-022 Glyph table (hex) for 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. Letter case: A b C d E F.
REQ-023 A blanked digit drives seg_o=7F and dp_o=1, and its an_o bit stays 1 (all an_o bits high) for that slot.
REQ-024 For a non-blanked digit, an_o is the index bit low and all others high, and dp_o = ~dp.

Reset
REQ-025 While rst_n=0: prescaler=0, index=0, pending_o=0, frame_o=0, seg_o=7F, dp_o=1, an_o all 1.
REQ-026 On reset, both buffers clear to val=0, dp=0 and blank all 1, so the display stays dark until the first commit.
REQ-027 Reset asserted mid-frame discards pending shadow data.

Configuration
REQ-028 Macro SEG7_LZ_SUPPRESS_EN; when defined, leading-zero suppression is compiled in.
REQ-029 With the macro defined, active digits above the most significant nonzero digit are treated as blanked; digit 0 is never suppressed.
REQ-030 Suppression is computed from the active buffer and ORed with blank_i state.
REQ-031 Without the macro, no suppression logic exists and zero digits display glyph 40.

Verification (DIGITS=4, TICK_DIV=4)
REQ-032 Reset release, no load -> an_o=F, seg_o=7F for 3 frames; frame_o pulses every 16 cycles.
REQ-033 Load val_i=16'h12AB, blank_i=0 -> pending_o=1 until the next frame_o, then slots 0..3 show seg 03,08,24,79 with an_o E,D,B,7.
REQ-034 Load 16'h1111, then load 16'h2222 before the frame boundary -> only 2222 (seg 24) is displayed; pending_o clears once.
REQ-035 load_i in the frame_o cycle -> the prior shadow is displayed and pending_o stays 1 until the next frame.
REQ-036 With SEG7_LZ_SUPPRESS_EN, load 16'h0050 -> digits 3 and 2 are dark (an_o F), and digits 1 and 0 show 12 and 40.
REQ-037 rst_n pulsed low mid-scan with pending_o=1 -> outputs immediately take reset values and the shadow is discarded.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with shadow/active display buffers.
// Optional leading-zero suppression compiled in with SEG7_LZ_SUPPRESS_EN.
module seg7_scan_driver #(
    parameter int DIGITS   = 8,
    parameter int TICK_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   val_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
    input  logic                  load_i,
    output logic                  pending_o,
    output logic                  frame_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  wrap;

    logic [4*DIGITS-1:0]   sh_val;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     sh_blank;
    logic [4*DIGITS-1:0]   act_val;
    logic [DIGITS-1:0]     act_dp;
    logic [DIGITS-1:0]     act_blank;

    logic [DIGITS-1:0]     supp;
    logic [DIGITS-1:0]     dark;
    logic [3:0]            nib;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign tick    = (presc == PLAST);
    assign wrap    = tick && (idx == ILAST);
    assign frame_o = wrap;

    // Prescaler and digit index; index steps once per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= (idx == ILAST) ? '0 : idx + 1'b1;
        end
    end

    // Shadow capture and frame-aligned commit to the active buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val    <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
            act_val   <= '0;
            act_dp    <= '0;
            act_blank <= '1;
            pending_o <= 1'b0;
        end else begin
            if (wrap && pending_o) begin
                act_val   <= sh_val;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
                pending_o <= 1'b0;
            end
            if (load_i) begin
                sh_val    <= val_i;
                sh_dp     <= dp_i;
                sh_blank  <= blank_i;
                pending_o <= 1'b1;
            end
        end
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    // Dark every digit above the most significant nonzero one; digit 0 stays lit.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        supp       = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (act_val[4*k +: 4] != 4'h0)
                zero_above = 1'b0;
            supp[k] = zero_above;
        end
    end
`else
    assign supp = '0;
`endif

    assign dark = act_blank | supp;
    assign nib  = act_val[{idx, 2'b00} +: 4];

    // Registered segment/anode drive for the digit at the current index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o <= 7'h7F;
            dp_o  <= 1'b1;
            an_o  <= '1;
        end else if (dark[idx]) begin
            seg_o <= 7'h7F;
            dp_o  <= 1'b1;
            an_o  <= '1;
        end else begin
            seg_o <= glyph(nib);
            dp_o  <= ~act_dp[idx];
            an_o  <= ~(DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, TICK_DIV=4).
// Reference model tracks time since reset and buffer contents arithmetically.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int TD = 4;
    localparam int F  = D * TD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] val_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;
    logic        pending_o;
    logic        frame_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;

    seg7_scan_driver #(.DIGITS(D), .TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .val_i     (val_i),
        .dp_i      (dp_i),
        .blank_i   (blank_i),
        .load_i    (load_i),
        .pending_o (pending_o),
        .frame_o   (frame_o),
        .seg_o     (seg_o),
        .dp_o      (dp_o),
        .an_o      (an_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       pend;
        logic       frame;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    logic [6:0] gtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [15:0] m_sv, m_av;
    logic [3:0]  m_sd, m_ad, m_sb, m_ab;
    bit          m_pend;
    int          c;

    function automatic exp_t reset_exp();
        exp_t e;
        e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.pend = 1'b0; e.frame = 1'b0;
        return e;
    endfunction

    function automatic bit is_dark(int k);
        bit d;
        d = m_ab[k];
`ifdef SEG7_LZ_SUPPRESS_EN
        if (k > 0 && (m_av >> (4 * k)) == 16'h0) d = 1'b1;
`endif
        return d;
    endfunction

    task automatic check(string name, logic [7:0] got, logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: one expected output set per clock edge.
    initial forever begin
        exp_t       e;
        int         s;
        logic [3:0] nib;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_sv = '0; m_av = '0; m_sd = '0; m_ad = '0;
            m_sb = 4'hF; m_ab = 4'hF; m_pend = 0; c = 0;
            q.delete();
            q.push_back(reset_exp());
        end else begin
            s = (c / TD) % D;
            if (is_dark(s)) begin
                e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF;
            end else begin
                nib   = 4'((m_av >> (4 * s)) & 16'hF);
                e.seg = gtab[nib];
                e.dp  = ~m_ad[s];
                e.an  = 4'hF & ~(4'(1) << s);
            end
            if ((c % F) == F - 1 && m_pend) begin
                m_av = m_sv; m_ad = m_sd; m_ab = m_sb; m_pend = 0;
            end
            if (load_i) begin
                m_sv = val_i; m_sd = dp_i; m_sb = blank_i; m_pend = 1;
            end
            e.pend  = m_pend;
            e.frame = ((c + 1) % F) == F - 1;
            c++;
            q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            pops++;
            check("seg",     {1'b0, seg_o}, {1'b0, e.seg});
            check("dp",      {7'b0, dp_o},  {7'b0, e.dp});
            check("an",      {4'b0, an_o},  {4'b0, e.an});
            check("pending", {7'b0, pending_o}, {7'b0, e.pend});
            check("frame",   {7'b0, frame_o},   {7'b0, e.frame});
        end
    end

    task automatic do_load(logic [15:0] v, logic [3:0] d, logic [3:0] b);
        val_i   = v;
        dp_i    = d;
        blank_i = b;
        load_i  = 1'b1;
        @(negedge clk);
        load_i  = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_load();
        logic [3:0] b;
        b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        do_load(16'($urandom), 4'($urandom), b);
    endtask

    initial begin
        bit found;
        idle(3);
        rst_n = 1'b1;
        idle(3 * F);

        do_load(16'h12AB, 4'h0, 4'h0);
        idle(2 * F + 5);

        do_load(16'h1111, 4'h0, 4'h0);
        idle(3);
        do_load(16'h2222, 4'h0, 4'h0);
        idle(2 * F + 3);

        do_load(16'h3456, 4'h5, 4'h0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (frame_o) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_wait got none want frame_o within 200 cycles");
        end
        do_load(16'h789A, 4'hA, 4'h2);
        idle(2 * F + 2);

        do_load(16'h0050, 4'h0, 4'h0);
        idle(2 * F);
        do_load(16'h0000, 4'h1, 4'h0);
        idle(2 * F);

        repeat (30) begin
            rand_load();
            idle($urandom_range(1, 40));
        end

        do_load(16'hBEEF, 4'hF, 4'h0);
        idle(5);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_seg",  {1'b0, seg_o},   8'h7F);
        check("rst_an",   {4'b0, an_o},    8'h0F);
        check("rst_dp",   {7'b0, dp_o},    8'h01);
        check("rst_pend", {7'b0, pending_o}, 8'h00);
        check("rst_frame", {7'b0, frame_o}, 8'h00);
        idle(3);
        rst_n = 1'b1;
        idle(3 * F);

        repeat (30) begin
            rand_load();
            idle($urandom_range(1, 40));
        end
        idle(2 * F);

        checks++;
        if (pops < 500) begin
            errors++;
            $display("FAIL scoreboard_pops got %0d want >= 500", pops);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
